// File: rtl/io_regfile.sv
// Register file with a prescaled ADC sample register, a ready/overrun status register
// and a registered debug view. Define IO_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module io_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADC_W    = 8,
    parameter int ADC_REG  = 1,
    parameter int RDY_REG  = 8,
    parameter int PRESCALE = 500
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     ctrl_writeEnable,
    input  logic [$clog2(DEPTH)-1:0] ctrl_writeReg,
    input  logic [$clog2(DEPTH)-1:0] ctrl_readRegA,
    input  logic [$clog2(DEPTH)-1:0] ctrl_readRegB,
    input  logic [WIDTH-1:0]         data_writeReg,
    input  logic [ADC_W-1:0]         adc_in,
    output logic [WIDTH-1:0]         data_readRegA,
    output logic [WIDTH-1:0]         data_readRegB,
    output logic [15:0]              testing
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(PRESCALE);
    localparam int TW = (WIDTH < 16) ? WIDTH : 16;
    localparam logic [AW-1:0] ADC_IDX = AW'(ADC_REG);
    localparam logic [AW-1:0] RDY_IDX = AW'(RDY_REG);
    localparam logic [PW-1:0] CNT_MAX = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [ADC_W-1:0] sync1_q, sync2_q;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [15:0]      testing_q, testing_d;
    logic [WIDTH-1:0] sample_ext;
    logic             tick;
    logic             wr_rdy;
    logic             ready_n, ovr_n;

    function automatic logic is_general(input logic [AW-1:0] a);
        return (a != '0) && (a != ADC_IDX) && (a != RDY_IDX);
    endfunction

    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        sample_ext = '0;
        sample_ext[ADC_W-1:0] = sync2_q;

        regs_d = regs_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ctrl_writeEnable && (ctrl_writeReg == AW'(i)) && is_general(AW'(i))) begin
                regs_d[i] = data_writeReg;
            end
        end
        regs_d[0] = '0;

        if (tick) begin
            regs_d[ADC_REG] = sample_ext;
        end

        // A tick always wins over a clearing write; overrun uses the pre-edge ready.
        wr_rdy  = ctrl_writeEnable && (ctrl_writeReg == RDY_IDX);
        ready_n = (regs_q[RDY_REG][0] & ~(wr_rdy & ~data_writeReg[0])) | tick;
        ovr_n   = (regs_q[RDY_REG][1] & ~(wr_rdy & ~data_writeReg[1]))
                  | (tick & regs_q[RDY_REG][0]);
        regs_d[RDY_REG]    = '0;
        regs_d[RDY_REG][0] = ready_n;
        regs_d[RDY_REG][1] = ovr_n;

        testing_d = '0;
        testing_d[TW-1:0] = regs_q[ADC_REG][TW-1:0];
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            testing_q <= '0;
        end else begin
            regs_q    <= regs_d;
            sync1_q   <= adc_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            testing_q <= testing_d;
        end
    end

    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        data_readRegB = regs_q[ctrl_readRegB];
`ifdef IO_REGFILE_BYPASS_EN
        // Forward only general registers; r0 and the status/sample registers never bypass.
        if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) && is_general(ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
        end
        if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) && is_general(ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
        end
`endif
    end

    assign testing = testing_q;

endmodule

// File: tb/tb_io_regfile.sv
// Scoreboard bench for io_regfile: stimulus queues expected read/debug values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_io_regfile;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [7:0]  adc_in;
    logic [31:0] data_readRegA, data_readRegB;
    logic [15:0] testing;

    io_regfile dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .adc_in           (adc_in),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .testing          (testing)
    );

    always #5 clock = ~clock;

    // 0 = read port A, 1 = read port B, 2 = testing
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    task automatic expect_out(input int sel, input logic [31:0] val, input string name);
        sel_q.push_back(sel);
        exp_q.push_back(val);
        name_q.push_back(name);
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clock);
            cyc++;
        end
        #1;
    endtask

    always @(negedge clock) begin
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] e;
            logic [31:0] act;
            string       nm;
            s  = sel_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = (s == 0) ? data_readRegA : (s == 1) ? data_readRegB : {16'h0, testing};
            n_vec++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e);
            end
        end
    end

    initial begin
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd8;
        data_writeReg    = '0;
        adc_in           = 8'hA5;

        @(posedge clock); #1;
        expect_out(0, 32'h0, "reset_r5");
        expect_out(1, 32'h0, "reset_rdy");
        expect_out(2, 32'h0, "reset_testing");
        @(posedge clock); #1;
        ctrl_reset_n = 1'b1;
        cyc = 0;

        // r5 write, then r0 write discarded
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd5;
        step_to(1);
        ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF;
        expect_out(0, 32'hDEADBEEF, "r5_portA");
        expect_out(1, 32'hDEADBEEF, "r5_portB");
        step_to(2);
        ctrl_writeEnable = 1'b0; ctrl_readRegA = 5'd0;
        expect_out(0, 32'h0, "r0_after_write");
        expect_out(1, 32'hDEADBEEF, "r5_still");

        // Write to ADC_REG ignored (never forwarded either)
        step_to(3);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd1; data_writeReg = 32'h12345678;
        ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd8;
        expect_out(0, 32'h0, "adc_write_same_cycle");
        expect_out(1, 32'h0, "rdy_before_tick");
        step_to(4);
        ctrl_writeReg = 5'd9; data_writeReg = 32'h00001111;
        expect_out(0, 32'h0, "adc_write_ignored");

        // Same-cycle write/read of r9
        step_to(5);
        data_writeReg = 32'h00001234; ctrl_readRegA = 5'd9;
`ifdef IO_REGFILE_BYPASS_EN
        expect_out(0, 32'h00001234, "r9_same_cycle_bypass");
`else
        expect_out(0, 32'h00001111, "r9_same_cycle_old");
`endif
        step_to(6);
        ctrl_writeEnable = 1'b0;
        expect_out(0, 32'h00001234, "r9_after_write");

        // First tick: ADC loaded at edge 500
        step_to(499);
        ctrl_readRegA = 5'd1; ctrl_readRegB = 5'd8;
        expect_out(0, 32'h0, "adc_before_tick");
        expect_out(1, 32'h0, "rdy_before_tick499");
        step_to(500);
        expect_out(0, 32'h000000A5, "adc_tick1");
        expect_out(1, 32'h1, "rdy_tick1");
        expect_out(2, 32'h0, "testing_lag");
        step_to(501);
        expect_out(2, 32'h00A5, "testing_tick1");

        // Clear between ticks
        step_to(510);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd8; data_writeReg = 32'h0;
        step_to(511);
        ctrl_writeEnable = 1'b0;
        expect_out(1, 32'h0, "rdy_cleared");

        // Two ticks without clearing -> overrun
        step_to(1000);
        adc_in = 8'h3C;
        expect_out(1, 32'h1, "rdy_tick2");
        expect_out(0, 32'h000000A5, "adc_tick2");
        step_to(1500);
        expect_out(1, 32'h3, "rdy_overrun");
        expect_out(0, 32'h0000003C, "adc_tick3");
        step_to(1501);
        expect_out(2, 32'h003C, "testing_tick3");

        // Clear overrun only
        step_to(1510);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd8; data_writeReg = 32'h1;
        step_to(1511);
        ctrl_writeEnable = 1'b0;
        expect_out(1, 32'h1, "rdy_clear_ovr_only");

        // Clearing write exactly on the tick cycle: tick wins
        step_to(1999);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd8; data_writeReg = 32'h0;
        step_to(2000);
        ctrl_writeEnable = 1'b0;
        expect_out(1, 32'h3, "rdy_tick_vs_clear");

        // Mid-count reset
        step_to(2250);
        ctrl_reset_n = 1'b0;
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd8;
        #1;
        expect_out(0, 32'h0, "reset_mid_r5");
        expect_out(1, 32'h0, "reset_mid_rdy");
        expect_out(2, 32'h0, "reset_mid_testing");
        step_to(2253);
        ctrl_reset_n = 1'b1;
        cyc = 0;
        ctrl_readRegA = 5'd1;
        step_to(499);
        expect_out(1, 32'h0, "rdy_no_early_tick");
        expect_out(0, 32'h0, "adc_no_early_tick");
        step_to(500);
        expect_out(1, 32'h1, "rdy_tick_after_reset");
        expect_out(0, 32'h0000003C, "adc_tick_after_reset");

        step_to(502);
        for (int i = 0; i < 10 && sel_q.size() > 0; i++) @(negedge clock);
        if (sel_q.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", sel_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/io_regfile.md
IO_REGFILE -- requirements
Module: io_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and data port.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; power of two, 16..32.
REQ-003 SHALL have parameter ADC_W, default 8, sample width; 1..WIDTH.
REQ-004 SHALL have parameter ADC_REG, default 1, index of the read-only sample register.
REQ-005 SHALL have parameter RDY_REG, default 8, index of the status register.
REQ-006 SHALL have parameter PRESCALE, default 500, clocks per sample; >=2.
REQ-007 SHALL have port clock, input, 1, the single clock; all state on its rising edge.
REQ-008 SHALL have port ctrl_reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port ctrl_writeEnable, input, 1, write strobe.
REQ-010 SHALL have ports ctrl_writeReg, ctrl_readRegA and ctrl_readRegB, input, log2(DEPTH), register addresses.
REQ-011 SHALL have port data_writeReg, input, WIDTH, write data.
REQ-012 SHALL have port adc_in, input, ADC_W, asynchronous converter bus.
REQ-013 SHALL have ports data_readRegA and data_readRegB, output, WIDTH, read data.
REQ-014 SHALL have port testing, output, 16, registered debug view.

Function
REQ-015 Register 0 SHALL always read 0; writes to it are discarded.
REQ-016 A general register (not 0, ADC_REG or RDY_REG) SHALL load data_writeReg on a clock edge when ctrl_writeEnable=1 and ctrl_writeReg matches its index.
REQ-017 Read ports SHALL be combinational, independent, and may address the same register.
REQ-018 adc_in SHALL pass through a two-flop synchroniser (2-cycle latency) before use.
REQ-019 A prescale counter SHALL count 0..PRESCALE-1 and wrap to 0; the cycle at PRESCALE-1 is the sample tick.
REQ-020 On a sample tick, ADC_REG SHALL load the zero-extended synchronised sample; it is visible on the read ports the next cycle.
REQ-021 ADC_REG SHALL ignore all writes.
REQ-022 RDY_REG bit0 (ready) SHALL be set on every sample tick.
REQ-023 RDY_REG bit1 (overrun) SHALL be set on a sample tick if ready is already 1.
REQ-024 A write to RDY_REG SHALL clear each of bits 0 and 1 whose data_writeReg bit is 0; a write bit of 1 leaves that status bit unchanged.
REQ-025 If a sample tick and a clearing write to RDY_REG occur in the same cycle, the tick SHALL win: ready ends at 1, and overrun is set per REQ-023 from the pre-edge ready.
REQ-026 RDY_REG bits WIDTH-1..2 SHALL always read 0.
REQ-027 testing SHALL be registered and equal ADC_REG[15:0] one cycle after ADC_REG changes, zero-padded when WIDTH<16.

Reset
REQ-028 While ctrl_reset_n=0, the block SHALL asynchronously clear all registers, the synchroniser, the prescale counter and testing to 0.
REQ-029 Writes and sample ticks SHALL be suppressed while ctrl_reset_n=0.
REQ-030 After deassertion, the first sample tick SHALL occur PRESCALE cycles later.
REQ-031 Reset mid-count SHALL discard any partial prescale count.

Configuration
REQ-032 Macro IO_REGFILE_BYPASS_EN defined: a read port addressing the register being written in the same cycle (general registers only) SHALL return data_writeReg combinationally.
REQ-033 Macro IO_REGFILE_BYPASS_EN not defined: a read port SHALL return the stored value, and the new value SHALL appear the cycle after the write edge.
REQ-034 Register 0, ADC_REG and RDY_REG SHALL never be bypassed in either configuration.

Verification
REQ-035 Reset, then write 0xDEADBEEF to r5 and read it on A and B -> both read 0xDEADBEEF; r0 reads 0 after a write of 0xFFFFFFFF to r0.
REQ-036 Hold adc_in=0xA5 from reset -> at cycle 500 after reset ADC_REG=0x000000A5, RDY_REG=0x1, and testing=0x00A5 one cycle later.
REQ-037 Write 0x0 to RDY_REG between ticks -> RDY_REG=0; let two ticks pass without clearing -> RDY_REG=0x3.
REQ-038 Write 0x0 to RDY_REG exactly on a sample tick while ready=1 -> RDY_REG=0x3.
REQ-039 Write 0x1234 to r9 while reading r9 on A in the same cycle -> A=0x1234 with IO_REGFILE_BYPASS_EN defined, and the old value without it.
REQ-040 Assert ctrl_reset_n=0 at prescale count 250 for 3 cycles -> all outputs read 0 immediately, and the next tick occurs 500 cycles after release.
